fifo_step_sequencer: RTL

Drains the 8-bit SPI command FIFO and sequences its contents into timed step/direction pulses for eight motor axes. It reads 4-byte motion records (step mask, direction bits, 16-bit hold period), drives direction lines with a setup delay, emits a fixed-width step pulse on the selected axes, then dwells for the programmed period before fetching the next record. It sits between the FIFO read port and the parallel output pins and replaces the fill-then-deplete scheme.

---
 rtl/fifo_step_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fifo_step_sequencer.sv
// Drains 4-byte motion records from the SPI command FIFO and turns each into a
// direction setup, a fixed-width step pulse on the masked axes, and a timed dwell.
module fifo_step_sequencer #(
    parameter int unsigned PULSE_WIDTH = 8,
    parameter int unsigned DIR_SETUP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_read_en,
    input  logic [7:0]  fifo_data,
    output logic [7:0]  step,
    output logic [7:0]  dir,
    output logic        busy,
    output logic        underrun,
    input  logic        clear_underrun,
    output logic [15:0] records_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DIR_WAIT,
        PULSE,
        HOLD
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_WIDTH - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [7:0]  mask_byte;
    logic [7:0]  dir_byte;
    logic [7:0]  period_hi;
    logic [7:0]  period_lo;
    logic [15:0] cnt;
    logic        cnt_zero;
    logic        hold_last;
    logic        underrun_set;

    assign cnt_zero  = (cnt == '0);
    // A zero period still spends one cycle in HOLD, same as period 1.
    assign hold_last = (cnt <= 16'd1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next   = state;
        fifo_read_en = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_read_en = 1'b1;
                    state_next   = LOAD;
                end else if (idx == 2'd0) begin
                    state_next = IDLE;
                end else begin
                    underrun_set = 1'b1;
                end
            end
            LOAD: begin
                state_next = (idx == 2'd3) ? DIR_WAIT : FETCH;
            end
            DIR_WAIT: begin
                if (cnt_zero) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    state_next = (enable && !fifo_empty) ? FETCH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            mask_byte    <= '0;
            dir_byte     <= '0;
            period_hi    <= '0;
            period_lo    <= '0;
            cnt          <= '0;
            step         <= '0;
            dir          <= '0;
            underrun     <= 1'b0;
            records_done <= '0;
        end else begin
            state <= state_next;

            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end

            // Registered step: loaded on entry to PULSE, dropped on exit.
            step <= (state_next == PULSE) ? mask_byte : '0;

            case (state)
                IDLE: begin
                    idx <= '0;
                end
                LOAD: begin
                    case (idx)
                        2'd0: mask_byte <= fifo_data;
                        2'd1: dir_byte  <= fifo_data;
                        2'd2: period_hi <= fifo_data;
                        2'd3: begin
                            period_lo <= fifo_data;
                            dir       <= dir_byte;
                        end
                        default: ;
                    endcase
                    idx <= idx + 2'd1;
                    cnt <= SETUP_LAST;
                end
                DIR_WAIT: begin
                    cnt <= cnt_zero ? PULSE_LAST : cnt - 16'd1;
                end
                PULSE: begin
                    cnt <= cnt_zero ? {period_hi, period_lo} : cnt - 16'd1;
                end
                HOLD: begin
                    if (hold_last) begin
                        records_done <= records_done + 16'd1;
                        idx          <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
